mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit implementing the RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage; the core stalls on it through a valid/ready handshake.
- Iterative radix-2 datapath: shift-add for multiply, restoring shift-subtract for divide.
- Special divide cases resolve early; the pipeline can flush an operation in flight.

Parameters:
- XLEN, 32, operand/result width in bits (32 or 64).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  md_op_e (3)  operation, encoded as RV funct3.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- flush_i  in  1  abort any operation in flight.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result.
- zero_o  out  1  result_o == 0, combinational from result_o.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State IDLE.
  - ready_o=1, valid_o=0, result_o=0, zero_o=1.
  - Iteration counter and internal registers cleared.
- States: IDLE, CALC, DONE.
  - IDLE: ready_o=1. Accept when valid_i&&ready_o&&!flush_i; latch op, operands, sign flags and absolute values.
    - Normal op -> CALC with counter=XLEN.
    - Special case -> DONE directly with result preloaded.
  - CALC: ready_o=0. One iteration per cycle, counter decrements; at counter==1 the final value is registered -> DONE.
  - DONE: valid_o=1, ready_o=0, result_o held stable. valid_o&&ready_i -> IDLE. No accept in the same cycle (no back-to-back overlap).
- Latency: valid_o rises XLEN+1 cycles after the accept edge for normal ops, 1 cycle after for special cases. The unit is not pipelined; throughput is one operation per latency+1 cycles minimum.
- Multiply:
  - Iterate on magnitudes into a 2*XLEN product; negate at the end when the operand signs differ.
  - Signedness per operand: MULH s×s, MULHSU s×u, MULHU u×u, MUL low half (signedness irrelevant).
  - MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
- Divide:
  - Iterate on magnitudes.
  - Quotient negated when signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Special cases (early-out, 1-cycle):
  - b==0: DIV/DIVU quotient = all ones; REM/REMU remainder = a_i.
  - Signed overflow, a==most negative and b==-1: DIV = a_i, REM = 0.
  - No exceptions raised.
- flush_i:
  - Any state -> IDLE next edge; valid_o=0 next cycle and no result is delivered.
  - flush_i with valid_i in IDLE: the request is not accepted.
  - flush_i and ready_i both asserted in DONE: go to IDLE; result is counted as dropped.
- Reset mid-operation: immediate return to reset values; no stale valid_o afterwards.
- Unknown op encoding is impossible (all 8 funct3 values are defined).
- Inputs are sampled only at accept; later changes to a_i, b_i or op_i are ignored.

Decomposition:
- Package mdu_pkg holds:
  - md_op_e enum (3-bit): MD_MUL=0, MD_MULH=1, MD_MULHSU=2, MD_MULHU=3, MD_DIV=4, MD_DIVU=5, MD_REM=6, MD_REMU=7.
  - md_state_e enum (IDLE, CALC, DONE).
  - Helper function is_div(op).
- data_t and XLEN-related typedefs come from common_pkg.
- No sub-module: control and the shared shift datapath live in one module of roughly 200-300 lines.

Test Plan (XLEN=32):
- MUL a=7, b=6, ready_i=1 -> valid_o 33 cycles after accept; result 42, zero_o=0; ready_o returns 1 the cycle after the handshake.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000, zero_o=1. MULHSU with the same operands -> 0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF after 1 cycle. REMU with the same operands -> 0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 after 1 cycle. REM with the same operands -> 0.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> valid_o stays 1, result_o stable, valid_i ignored (ready_o=0). Then ready_i=1 -> IDLE.
- Abort: assert flush_i 5 cycles into CALC -> valid_o never rises for that op; next DIVU 9/3 returns 3 with full latency. Also assert rst_i mid-CALC -> all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/common_pkg.sv
// Shared core-wide types: default datapath width and the machine-word type.
package common_pkg;
  localparam int unsigned XLEN_DEFAULT = 32;
  typedef logic [XLEN_DEFAULT-1:0] data_t;
endpackage

// File: rtl/mdu_pkg.sv
// Operation encoding (RV funct3), FSM states and decode helpers for the multiply/divide unit.
package mdu_pkg;
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(md_op_e op);
    return op[2];
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// early-out for divide-by-zero and signed overflow, valid/ready on both sides, flushable.
module mdu_iter
  import common_pkg::*;
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);
  localparam int unsigned CntW = $clog2(XLEN + 1);

  md_state_e         r_state, w_state_d;
  md_op_e            r_op;
  logic [CntW-1:0]   r_cnt;
  logic              r_neg;
  logic [XLEN-1:0]   r_opb;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg_d;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum, w_div_part, w_div_trial;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  // Operand decode at accept: signedness, magnitudes and the sign to apply at the end
  assign w_a_sgn = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) ||
                   (op_i == MD_REM);
  assign w_b_sgn = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
  assign w_a_neg = w_a_sgn & a_i[XLEN-1];
  assign w_b_neg = w_b_sgn & b_i[XLEN-1];
  assign w_a_mag = w_a_neg ? -a_i : a_i;
  assign w_b_mag = w_b_neg ? -b_i : b_i;
  assign w_neg_d = (op_i == MD_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_b_zero  = (b_i == '0);
  assign w_ovf     = ((op_i == MD_DIV) || (op_i == MD_REM)) &&
                     (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
  assign w_special = is_div(op_i) && (w_b_zero || w_ovf);

  // funct3 bit 1 separates REM/REMU from DIV/DIVU
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = op_i[1] ? a_i : '1;
    else          w_special_res = op_i[1] ? '0 : a_i;
  end

  // One radix-2 step: multiply keeps {partial, multiplier}; divide keeps {remainder, quotient}
  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt   = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_part  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_trial = w_div_part - {1'b0, r_opb};
  assign w_div_nxt   = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_acc_nxt   = is_div(r_op) ? w_div_nxt : w_mul_nxt;

  assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo  = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem  = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    unique case (r_op)
      MD_MUL:                       w_final = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_final = w_quo;
      MD_REM, MD_REMU:              w_final = w_rem;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    unique case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) w_state_d = w_special ? DONE : CALC;
      end
      CALC: if (r_cnt == CntW'(1)) w_state_d = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
    // Flush wins over everything, including a handshake in DONE
    if (flush_i) w_state_d = IDLE;
  end

  assign w_accept = ready_o && valid_i && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op     <= MD_MUL;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= op_i;
      r_cnt <= CntW'(XLEN);
      r_neg <= w_neg_d;
      r_opb <= w_b_mag;
      r_acc <= {{XLEN{1'b0}}, w_a_mag};
      if (w_special) r_result <= w_special_res;
    end else if (r_state == CALC && !flush_i) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - CntW'(1);
      if (r_cnt == CntW'(1)) r_result <= w_final;
    end
  end

  assign result_o = r_result;
  assign zero_o   = (result_o == '0);
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32): directed vectors, randomized ops against an
// arithmetic reference model, backpressure, flush and asynchronous reset.
module tb_mdu_iter;
  import common_pkg::*;
  import mdu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int NormLat = XLEN + 1;

  logic   clk = 1'b0;
  logic   rst_i, valid_i, ready_o, flush_i, valid_o, ready_i, zero_o;
  md_op_e op_i;
  data_t  a_i, b_i, result_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .result_o(result_o),
    .zero_o  (zero_o)
  );

  // Reference: plain 64-bit arithmetic plus the RISC-V divide special-case rules
  function automatic data_t model(md_op_e op, data_t a, data_t b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MUL:    begin p = ua * ub;            return p[31:0];  end
      MD_MULH:   begin p = sa * sb;            return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub);  return p[63:32]; end
      MD_MULHU:  begin p = ua * ub;            return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return data_t'($signed(a) / $signed(b));
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return data_t'($signed(a) % $signed(b));
      end
      MD_DIVU: return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(md_op_e op, data_t a, data_t b);
    if ((op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) && b == 0) return 1;
    if ((op inside {MD_DIV, MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return NormLat;
  endfunction

  // Issue one request from IDLE; return the result and the edge count until valid_o (bounded)
  task automatic run_op(input md_op_e op, input data_t a, input data_t b,
                        output data_t res, output int lat);
    @(negedge clk);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op_i = md_op_e'($urandom_range(0, 7));
    a_i = $urandom;
    b_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({ready_o, valid_o, zero_o} !== 3'b101 || result_o !== '0) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b zero=%b res=%h, want 1 0 1 0", ready_o, valid_o, zero_o,
               result_o);
    end
    @(negedge clk); rst_i = 1'b0;
  endtask

  task automatic test_directed();
    md_op_e d_op[12] = '{MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_REM, MD_DIVU, MD_REMU,
                         MD_DIVU, MD_REMU, MD_DIV, MD_REM};
    data_t d_a[12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                       32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000,
                       32'h8000_0000};
    data_t d_b[12] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7,
                       32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    data_t d_exp[12] = '{32'd42, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                         32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000,
                         32'h0};
    int d_lat[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    data_t res;
    int lat;
    ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], res, lat);
      n_checks++;
      if (res !== d_exp[i] || lat !== d_lat[i] || zero_o !== (d_exp[i] == 0)) begin
        n_fail++;
        $display("FAIL directed[%0d] %s: res=%h lat=%0d zero=%b, want %h %0d %b", i,
                 d_op[i].name(), res, lat, zero_o, d_exp[i], d_lat[i], d_exp[i] == 0);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_release[%0d]: rdy=%b vld=%b, want 1 0", i, ready_o, valid_o);
      end
    end
  endtask

  task automatic test_random();
    md_op_e op;
    data_t a, b, res, exp;
    int lat, elat, sel;
    ready_i = 1'b1;
    for (int i = 0; i < 48; i++) begin
      op  = md_op_e'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(0, 15); end
        3: b = $urandom_range(1, 100);
        4: b = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: ;
      endcase
      exp  = model(op, a, b);
      elat = model_lat(op, a, b);
      run_op(op, a, b, res, lat);
      n_checks++;
      if (res !== exp || lat !== elat || zero_o !== (exp == 0)) begin
        n_fail++;
        $display("FAIL random[%0d] %s a=%h b=%h: res=%h lat=%0d zero=%b, want %h %0d %b", i,
                 op.name(), a, b, res, lat, zero_o, exp, elat, exp == 0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    data_t res;
    int lat;
    ready_i = 1'b0;
    run_op(MD_DIVU, 32'd100, 32'd7, res, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid_i = 1'b1; op_i = MD_DIVU; a_i = 32'h55; b_i = 32'd0;
      @(posedge clk); #1;
      n_checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'd14) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b res=%h, want 1 0 0000000e", i, valid_o,
                 ready_o, result_o);
      end
    end
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: vld=%b rdy=%b, want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_flush();
    data_t res;
    int lat;
    bit seen;
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b1; op_i = MD_DIV; a_i = 32'd1000; b_i = 32'd3;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (4) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_calc: vld=%b rdy=%b, want 0 1", valid_o, ready_o);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_result: valid_o seen=%b, want 0", seen);
    end
    run_op(MD_DIVU, 32'd9, 32'd3, res, lat);
    n_checks++;
    if (res !== 32'd3 || lat !== NormLat) begin
      n_fail++;
      $display("FAIL flush_next_op: res=%h lat=%0d, want 3 %0d", res, lat, NormLat);
    end
    @(posedge clk); #1;
    // A special-case request would show valid_o one edge later if it were wrongly accepted
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; op_i = MD_DIVU; a_i = 32'h77; b_i = 32'd0;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle: vld=%b rdy=%b, want 0 1", valid_o, ready_o);
    end
    ready_i = 1'b0;
    run_op(MD_REMU, 32'd9, 32'd0, res, lat);
    @(negedge clk);
    flush_i = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: vld=%b rdy=%b, want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_mid();
    data_t res;
    int lat;
    bit seen;
    ready_i = 1'b1;
    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'h3, res, lat);
    @(posedge clk); #1;
    @(negedge clk);
    valid_i = 1'b1; op_i = MD_MUL; a_i = 32'd123; b_i = 32'd45;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_i = 1'b1;
    #1;
    n_checks++;
    if ({ready_o, valid_o, zero_o} !== 3'b101 || result_o !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b vld=%b zero=%b res=%h, want 1 0 1 0", ready_o, valid_o,
               zero_o, result_o);
    end
    @(negedge clk); rst_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stale_valid: valid_o seen=%b, want 0", seen);
    end
    run_op(MD_MUL, 32'd7, 32'd6, res, lat);
    n_checks++;
    if (res !== 32'd42 || lat !== NormLat) begin
      n_fail++;
      $display("FAIL reset_recover: res=%h lat=%0d, want 2a %0d", res, lat, NormLat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    op_i = MD_MUL; a_i = '0; b_i = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
